multicycle_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS datapath. It sits directly downstream of the instruction fetch unit: it consumes the fetched 32-bit instruction and the ALU `zero` flag, and sequences each instruction through IF/ID/EXE/MEM/WB. It produces the `jump`, `branch` and PC-update strobes that the fetch unit consumes, plus the register-file, memory and ALU controls. It keeps an internal opcode/funct register and a retired-instruction counter.

---
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: fetched instruction and ALU zero flag in,
// PC/IR/register-file/memory strobes and ALU/extension selects out.
// No flow control: the controller owns sequencing, the datapath simply obeys.
//
// Ports (master = controller, slave = fetch unit / datapath):
//   instruction, zero                      : datapath -> controller
//   pc_wr, ir_wr, jump, branch, reg_wr,
//   mem_wr, reg_dst, alu_src, mem_to_reg,
//   ext_op, alu_op, state, illegal, retired: controller -> datapath
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instruction;
  logic             zero;
  logic             pc_wr;
  logic             ir_wr;
  logic             jump;
  logic             branch;
  logic             reg_wr;
  logic             mem_wr;
  logic             reg_dst;
  logic             alu_src;
  logic             mem_to_reg;
  logic [1:0]       ext_op;
  logic [2:0]       alu_op;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instruction, zero,
    output pc_wr, ir_wr, jump, branch, reg_wr, mem_wr, reg_dst, alu_src,
           mem_to_reg, ext_op, alu_op, state, illegal, retired
  );

  modport slave (
    output instruction, zero,
    input  pc_wr, ir_wr, jump, branch, reg_wr, mem_wr, reg_dst, alu_src,
           mem_to_reg, ext_op, alu_op, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences IF/ID/EXE/MEM/WB per instruction.
// Latency: 2 (j/illegal), 3 (beq), 4 (R/ori/lui/sw), 5 (lw) cycles per instruction.
// No backpressure: every state advances each clock; pc_wr pulses on the last cycle.
//
// Ports: clk, rst (async, active-high), bus (multicycle_ctrl_if.master).
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [5:0]       r_op;
  logic [5:0]       r_fn;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic w_is_r, w_r_ok, w_supported, w_is_lw, w_is_sw, w_is_beq, w_is_j;
  logic w_pc_wr, w_ir_wr, w_jump, w_branch, w_reg_wr, w_mem_wr;
  logic w_reg_dst, w_mem_to_reg, w_alu_src, w_bad_id;
  logic [1:0] w_ext_op;
  logic [2:0] w_alu_op;

  // zero is consumed by the fetch unit together with branch; the controller
  // never gates on it. Only opcode and funct fields of the word are decoded.
  logic w_unused_bits;
  assign w_unused_bits = ^{bus.zero, bus.instruction[25:6]};

  // Opcode/funct decode of the latched instruction.
  assign w_is_r      = (r_op == OP_R);
  assign w_r_ok      = w_is_r && ((r_fn == FN_ADDU) || (r_fn == FN_SUBU) || (r_fn == FN_SLT));
  assign w_is_lw     = (r_op == OP_LW);
  assign w_is_sw     = (r_op == OP_SW);
  assign w_is_beq    = (r_op == OP_BEQ);
  assign w_is_j      = (r_op == OP_J);
  assign w_supported = w_r_ok || w_is_lw || w_is_sw || w_is_beq || w_is_j ||
                       (r_op == OP_ORI) || (r_op == OP_LUI);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  // Opcode/funct latch, loaded only while fetching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= '0;
      r_fn <= '0;
    end else if (r_state == S_IF) begin
      r_op <= bus.instruction[31:26];
      r_fn <= bus.instruction[5:0];
    end
  end

  // Sticky illegal flag and retired counter (wraps naturally).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_bad_id) r_illegal <= 1'b1;
      if (w_pc_wr)  r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:  w_next = S_ID;
      S_ID:  w_next = (w_is_j || !w_supported) ? S_IF : S_EXE;
      S_EXE: begin
        if (w_is_beq)               w_next = S_IF;
        else if (w_is_lw || w_is_sw) w_next = S_MEM;
        else                         w_next = S_WB;
      end
      S_MEM: w_next = w_is_sw ? S_IF : S_WB;
      S_WB:  w_next = S_IF;
      default: w_next = S_IF;  // unused codes 5-7 recover to fetch
    endcase
  end

  // Output decode.
  always_comb begin
    w_pc_wr      = 1'b0;
    w_ir_wr      = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_reg_wr     = 1'b0;
    w_mem_wr     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_bad_id     = 1'b0;
    w_alu_op     = 3'b000;
    w_alu_src    = 1'b0;
    w_ext_op     = 2'b00;
    case (r_state)
      S_IF:  w_ir_wr = 1'b1;
      S_ID: begin
        if (w_is_j) begin
          w_jump  = 1'b1;
          w_pc_wr = 1'b1;
        end else if (!w_supported) begin
          // Skip the instruction: advance PC and flag it.
          w_bad_id = 1'b1;
          w_pc_wr  = 1'b1;
        end
      end
      S_EXE: begin
        if (w_is_beq) begin
          w_branch = 1'b1;
          w_pc_wr  = 1'b1;
        end
      end
      S_MEM: begin
        if (w_is_sw) begin
          w_mem_wr = 1'b1;
          w_pc_wr  = 1'b1;
        end
      end
      S_WB: begin
        w_reg_wr     = 1'b1;
        w_pc_wr      = 1'b1;
        w_reg_dst    = w_is_r;
        w_mem_to_reg = w_is_lw;
      end
      default: ;
    endcase

    // ALU/extension selects are set in EXE and held through MEM and WB.
    if ((r_state == S_EXE) || (r_state == S_MEM) || (r_state == S_WB)) begin
      case (r_op)
        OP_R: begin
          if (r_fn == FN_SUBU)     w_alu_op = 3'b001;
          else if (r_fn == FN_SLT) w_alu_op = 3'b011;
          else                     w_alu_op = 3'b000;
        end
        OP_ORI: begin
          w_alu_op  = 3'b010;
          w_alu_src = 1'b1;
        end
        OP_LUI: begin
          w_alu_op  = 3'b100;
          w_alu_src = 1'b1;
          w_ext_op  = 2'b10;
        end
        OP_LW, OP_SW: begin
          w_alu_op  = 3'b000;
          w_alu_src = 1'b1;
          w_ext_op  = 2'b01;
        end
        OP_BEQ: begin
          // Compare by subtraction; offset sign-extended for the target adder.
          w_alu_op = 3'b001;
          w_ext_op = 2'b01;
        end
        default: ;
      endcase
    end
  end

  // Reset returns state to IF asynchronously, so enables are additionally
  // masked by rst to keep ir_wr and friends quiet while reset is held.
  assign bus.pc_wr      = w_pc_wr  & ~rst;
  assign bus.ir_wr      = w_ir_wr  & ~rst;
  assign bus.jump       = w_jump   & ~rst;
  assign bus.branch     = w_branch & ~rst;
  assign bus.reg_wr     = w_reg_wr & ~rst;
  assign bus.mem_wr     = w_mem_wr & ~rst;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src    = w_alu_src;
  assign bus.alu_op     = w_alu_op;
  assign bus.ext_op     = w_ext_op;
  assign bus.state      = r_state;
  assign bus.illegal    = r_illegal | w_bad_id;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;  // addu $3,$1,$2
  localparam logic [31:0] I_SUBU = 32'h0022_1823;  // subu $3,$1,$2
  localparam logic [31:0] I_SLT  = 32'h0022_182A;  // slt  $3,$1,$2
  localparam logic [31:0] I_ORI  = 32'h3424_00FF;  // ori  $4,$1,0xff
  localparam logic [31:0] I_LUI  = 32'h3C05_1234;  // lui  $5,0x1234
  localparam logic [31:0] I_LW   = 32'h8C26_0004;  // lw   $6,4($1)
  localparam logic [31:0] I_SW   = 32'hAC26_0008;  // sw   $6,8($1)
  localparam logic [31:0] I_BEQ  = 32'h1022_0002;  // beq  $1,$2,2
  localparam logic [31:0] I_J    = 32'h0800_0040;  // j    0x0000040
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;  // opcode 111111
  localparam logic [31:0] I_RBAD = 32'h0000_0000;  // R-type funct 000000
  localparam logic [31:0] I_JUNK = 32'hFFFF_FFFF;  // driven outside IF

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_ctrl_if #(.CNT_W(32)) ifa ();
  multicycle_ctrl_if #(.CNT_W(4))  ifb ();

  multicycle_ctrl #(.CNT_W(32)) dut_a (.clk(clk), .rst(rst),   .bus(ifa));
  multicycle_ctrl #(.CNT_W(4))  dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instruction class: 0 R-ok, 1 ori, 2 lui, 3 lw, 4 sw, 5 beq, 6 j, 7 illegal
  function automatic int cls_of(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'b000000: return (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b101010) ? 0 : 7;
      6'b001101: return 1;
      6'b001111: return 2;
      6'b100011: return 3;
      6'b101011: return 4;
      6'b000100: return 5;
      6'b000010: return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic int ncyc(input int c);
    case (c)
      3:       return 5;
      5:       return 3;
      6, 7:    return 2;
      default: return 4;
    endcase
  endfunction

  // Phase k of an instruction's trace -> state code (IF0 ID1 EXE2 MEM3 WB4).
  function automatic int state_at(input int c, input int k);
    if ((c == 0 || c == 1 || c == 2) && k == 3) return 4;  // skip MEM
    return k;
  endfunction

  logic [31:0] m_ins;
  logic [31:0] m_ret = '0;
  int          m_k = 0;
  bit          m_ill = 1'b0;
  int          mc, ms;
  bit          mlast;
  logic [2:0]  e_alu;
  logic [1:0]  e_ext;
  logic        e_src;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_state",   ifa.state, 0);
      chk("rst_pc_wr",   ifa.pc_wr, 0);
      chk("rst_ir_wr",   ifa.ir_wr, 0);
      chk("rst_jump",    ifa.jump, 0);
      chk("rst_branch",  ifa.branch, 0);
      chk("rst_reg_wr",  ifa.reg_wr, 0);
      chk("rst_mem_wr",  ifa.mem_wr, 0);
      chk("rst_alu_op",  ifa.alu_op, 0);
      chk("rst_ext_op",  ifa.ext_op, 0);
      chk("rst_illegal", ifa.illegal, 0);
      chk("rst_retired", ifa.retired, 0);
      m_k   = 0;
      m_ret = '0;
      m_ill = 1'b0;
    end else begin
      if (m_k == 0) m_ins = ifa.instruction;
      mc    = cls_of(m_ins);
      ms    = state_at(mc, m_k);
      mlast = (m_k == ncyc(mc) - 1);
      e_alu = 3'b000;
      e_src = 1'b0;
      e_ext = 2'b00;
      if (m_k >= 2) begin
        case (mc)
          0: e_alu = (m_ins[5:0] == 6'b100011) ? 3'b001 :
                     (m_ins[5:0] == 6'b101010) ? 3'b011 : 3'b000;
          1: begin e_alu = 3'b010; e_src = 1'b1; end
          2: begin e_alu = 3'b100; e_src = 1'b1; e_ext = 2'b10; end
          3, 4: begin e_alu = 3'b000; e_src = 1'b1; e_ext = 2'b01; end
          5: begin e_alu = 3'b001; e_ext = 2'b01; end
          default: ;
        endcase
      end
      chk("state",      ifa.state, ms);
      chk("ir_wr",      ifa.ir_wr, m_k == 0);
      chk("pc_wr",      ifa.pc_wr, mlast);
      chk("jump",       ifa.jump, mc == 6 && m_k == 1);
      chk("branch",     ifa.branch, mc == 5 && m_k == 2);
      chk("reg_wr",     ifa.reg_wr, mlast && ms == 4);
      chk("mem_wr",     ifa.mem_wr, mc == 4 && mlast);
      chk("reg_dst",    ifa.reg_dst, mc == 0 && ms == 4);
      chk("mem_to_reg", ifa.mem_to_reg, mc == 3 && ms == 4);
      chk("alu_op",     ifa.alu_op, e_alu);
      chk("alu_src",    ifa.alu_src, e_src);
      chk("ext_op",     ifa.ext_op, e_ext);
      chk("illegal",    ifa.illegal, m_ill || (mc == 7 && m_k == 1));
      chk("retired",    ifa.retired, m_ret);
      if (mc == 7 && m_k == 1) m_ill = 1'b1;
      if (mlast) begin
        m_ret = m_ret + 1;
        m_k   = 0;
      end else begin
        m_k++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at posedge+1 with the DUT in IF; returns at posedge+1 after ncyc edges.
  task automatic run_instr(input logic [31:0] ins, input int n);
    ifa.instruction = ins;
    @(posedge clk);
    #1 ifa.instruction = I_JUNK;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.instruction = I_JUNK;
    ifa.zero        = 1'b0;
    ifb.instruction = I_J;
    ifb.zero        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_state",   ifa.state, 0);
    chk("lit_rst_ir_wr",   ifa.ir_wr, 0);
    rst = 1'b0;
    ifa.instruction = I_ADDU;
    #1 chk("lit_first_ir_wr", ifa.ir_wr, 1);

    run_instr(I_ADDU, 4);
    run_instr(I_ORI,  4);
    run_instr(I_LUI,  4);
    run_instr(I_LW,   5);
    run_instr(I_SW,   4);
    chk("lit_retired_5", ifa.retired, 5);
    run_instr(I_SUBU, 4);
    run_instr(I_SLT,  4);

    ifa.zero = 1'b1;
    run_instr(I_BEQ, 3);
    ifa.zero = 1'b0;
    run_instr(I_BEQ, 3);
    chk("lit_retired_9", ifa.retired, 9);

    // j: check the ID cycle explicitly.
    ifa.instruction = I_J;
    @(posedge clk);
    #1 ifa.instruction = I_JUNK;
    chk("lit_j_jump",  ifa.jump, 1);
    chk("lit_j_pc_wr", ifa.pc_wr, 1);
    @(posedge clk);
    #1 chk("lit_j_next_if", ifa.state, 0);

    chk("lit_illegal_pre", ifa.illegal, 0);
    run_instr(I_BAD,  2);
    chk("lit_illegal_set", ifa.illegal, 1);
    run_instr(I_RBAD, 2);
    run_instr(I_ADDU, 4);
    chk("lit_illegal_stay", ifa.illegal, 1);
    chk("lit_retired_13",   ifa.retired, 13);

    // Reset in the WB cycle of an addu.
    ifa.instruction = I_ADDU;
    @(posedge clk);
    #1 ifa.instruction = I_JUNK;
    repeat (2) @(posedge clk);
    #1 chk("lit_wb_reg_wr", ifa.reg_wr, 1);
    rst = 1'b1;
    #1;
    chk("lit_arst_reg_wr",  ifa.reg_wr, 0);
    chk("lit_arst_state",   ifa.state, 0);
    chk("lit_arst_retired", ifa.retired, 0);
    chk("lit_arst_illegal", ifa.illegal, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    ifa.instruction = I_ADDU;
    #1 chk("lit_rel_ir_wr", ifa.ir_wr, 1);
    run_instr(I_ADDU, 4);
    chk("lit_retired_1", ifa.retired, 1);

    // 4-bit counter wrap with 17 back-to-back jumps; main DUT parked in reset.
    rst = 1'b1;
    rst_b = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("lit_wrap_15", ifb.retired, 15);
    repeat (2) @(posedge clk);
    #1 chk("lit_wrap_0", ifb.retired, 0);
    repeat (2) @(posedge clk);
    #1 chk("lit_wrap_1", ifb.retired, 1);
    chk("lit_b_illegal", ifb.illegal, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
